// File: rtl/scm_refill_pkg.sv
// Shared types and constants for the SCM refill write path.
// The packer assumes exactly two refill beats per SCM row.
package scm_refill_pkg;

    localparam int DEF_WADDR_WIDTH = 5;
    localparam int DEF_WDATA_WIDTH = 64;
    localparam int DEF_BEAT_WIDTH  = 32;

    localparam int NUM_ROWS      = 2 ** DEF_WADDR_WIDTH;
    localparam int BEATS_PER_ROW = DEF_WDATA_WIDTH / DEF_BEAT_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    function automatic int rows_for(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/scm_victim_rr.sv
// Round-robin victim way selector; one-hot pointer that rotates on each advance.
module scm_victim_rr
    import scm_refill_pkg::*;
#(
    parameter int NB_WAYS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv_i,
    output logic [NB_WAYS-1:0] way_o
);

    logic [NB_WAYS-1:0] ptr_r;

    // Pointer register: starts at way 0 and rotates left on every auto request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= NB_WAYS'(1);
        end else if (adv_i) begin
            ptr_r <= {ptr_r[NB_WAYS-2:0], ptr_r[NB_WAYS-1]};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign way_o = ptr_r;

endmodule

// File: rtl/scm_refill_write_packer.sv
// Packs pairs of 32b refill beats into 64b SCM rows and drives the SCM write port,
// holding WriteWay across the latch phase and reporting per-request completion.
module scm_refill_write_packer
    import scm_refill_pkg::*;
#(
    parameter int NB_WAYS     = 4,
    parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
    parameter int WDATA_WIDTH = DEF_WDATA_WIDTH,
    parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [WADDR_WIDTH-1:0] req_addr_i,
    input  logic [WADDR_WIDTH:0]   req_nrows_i,
    input  logic [NB_WAYS-1:0]     req_way_i,
    input  logic                   beat_valid_i,
    output logic                   beat_ready_o,
    input  logic [BEAT_WIDTH-1:0]  beat_data_i,
    input  logic                   beat_last_i,
    output logic                   done_valid_o,
    output logic                   done_err_o,
    output logic [NB_WAYS-1:0]     done_way_o,
    output logic                   WriteEnable,
    output logic [WADDR_WIDTH-1:0] WriteAddr,
    output logic [WDATA_WIDTH-1:0] WriteData,
    output logic [NB_WAYS-1:0]     WriteWay
);

    localparam int                   ROWS   = rows_for(WADDR_WIDTH);
    localparam logic [WADDR_WIDTH:0] ROWS_W = (WADDR_WIDTH+1)'(ROWS);

    if (BEATS_PER_ROW != 2 || WDATA_WIDTH != 2 * BEAT_WIDTH) begin : g_width_check
        $error("scm_refill_write_packer: a row must hold exactly two beats");
    end

    state_e                 state_r;
    logic [WADDR_WIDTH-1:0] row_r;
    logic [WADDR_WIDTH:0]   rows_left_r;
    logic [BEAT_WIDTH-1:0]  lo_r;
    logic                   err_r;
    logic                   req_fire_s;
    logic                   auto_adv_s;
    logic [NB_WAYS-1:0]     victim_way_s;

    assign req_fire_s = req_valid_i & req_ready_o;
    assign auto_adv_s = req_fire_s & ~(|req_way_i);

    scm_victim_rr #(
        .NB_WAYS (NB_WAYS)
    ) u_victim (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (auto_adv_s),
        .way_o (victim_way_s)
    );

    // Request FSM, beat packer, row counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            row_r        <= {WADDR_WIDTH{1'b0}};
            rows_left_r  <= {(WADDR_WIDTH+1){1'b0}};
            lo_r         <= {BEAT_WIDTH{1'b0}};
            err_r        <= 1'b0;
            req_ready_o  <= 1'b0;
            beat_ready_o <= 1'b0;
            done_valid_o <= 1'b0;
            done_err_o   <= 1'b0;
            done_way_o   <= {NB_WAYS{1'b0}};
            WriteEnable  <= 1'b0;
            WriteAddr    <= {WADDR_WIDTH{1'b0}};
            WriteData    <= {WDATA_WIDTH{1'b0}};
            WriteWay     <= {NB_WAYS{1'b0}};
        end else begin
            WriteEnable  <= 1'b0;
            done_valid_o <= 1'b0;
            done_err_o   <= 1'b0;
            done_way_o   <= {NB_WAYS{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        req_ready_o <= 1'b0;
                        row_r       <= req_addr_i;
                        rows_left_r <= req_nrows_i;
                        WriteWay    <= (|req_way_i) ? req_way_i : victim_way_s;
                        // Bad lengths take the FLUSH slot with no write so done timing matches.
                        if (req_nrows_i == {(WADDR_WIDTH+1){1'b0}} || req_nrows_i > ROWS_W) begin
                            state_r <= ST_FLUSH;
                            err_r   <= 1'b1;
                        end else begin
                            state_r      <= ST_LO;
                            beat_ready_o <= 1'b1;
                            err_r        <= 1'b0;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                ST_LO: begin
                    if (beat_valid_i && beat_ready_o) begin
                        lo_r <= beat_data_i;
                        if (beat_last_i) begin
                            state_r      <= ST_HOLD;
                            beat_ready_o <= 1'b0;
                            done_valid_o <= 1'b1;
                            done_err_o   <= 1'b1;
                            done_way_o   <= WriteWay;
                        end else begin
                            state_r <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (beat_valid_i && beat_ready_o) begin
                        WriteEnable <= 1'b1;
                        WriteAddr   <= row_r;
                        WriteData   <= {beat_data_i, lo_r};
                        row_r       <= row_r + WADDR_WIDTH'(1);
                        rows_left_r <= rows_left_r - (WADDR_WIDTH+1)'(1);
                        if (rows_left_r == (WADDR_WIDTH+1)'(1)) begin
                            state_r      <= ST_FLUSH;
                            beat_ready_o <= 1'b0;
                            err_r        <= ~beat_last_i;
                        end else if (beat_last_i) begin
                            state_r      <= ST_FLUSH;
                            beat_ready_o <= 1'b0;
                            err_r        <= 1'b1;
                        end else begin
                            state_r <= ST_LO;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_r      <= ST_HOLD;
                    done_valid_o <= 1'b1;
                    done_err_o   <= err_r;
                    done_way_o   <= WriteWay;
                end
                ST_HOLD: begin
                    state_r     <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    WriteWay    <= {NB_WAYS{1'b0}};
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_o  <= 1'b0;
                    beat_ready_o <= 1'b0;
                    WriteWay     <= {NB_WAYS{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scm_refill_write_packer.sv
// Directed bench for scm_refill_write_packer: hand-computed rows, ways and done status.
module tb_scm_refill_write_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_addr = 5'd0;
    logic [5:0]  req_nrows = 6'd0;
    logic [3:0]  req_way = 4'd0;
    logic        beat_valid = 1'b0;
    logic        beat_ready;
    logic [31:0] beat_data = 32'd0;
    logic        beat_last = 1'b0;
    logic        done_valid;
    logic        done_err;
    logic [3:0]  done_way;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [3:0]  wway;

    int vectors = 0;
    int errs = 0;

    logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3, c0, c1;

    scm_refill_write_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_nrows_i  (req_nrows),
        .req_way_i    (req_way),
        .beat_valid_i (beat_valid),
        .beat_ready_o (beat_ready),
        .beat_data_i  (beat_data),
        .beat_last_i  (beat_last),
        .done_valid_o (done_valid),
        .done_err_o   (done_err),
        .done_way_o   (done_way),
        .WriteEnable  (we),
        .WriteAddr    (waddr),
        .WriteData    (wdata),
        .WriteWay     (wway)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_req(input logic [4:0] a, input logic [5:0] n, input logic [3:0] w);
        int k;
        req_addr  = a;
        req_nrows = n;
        req_way   = w;
        req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("req_ready", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int k;
        beat_data  = d;
        beat_last  = last;
        beat_valid = 1'b1;
        k = 0;
        while (beat_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("beat_ready", {63'd0, beat_ready}, 64'd1);
        tick();
        beat_valid = 1'b0;
        beat_last  = 1'b0;
    endtask

    initial begin
        a0 = 32'hA000_0000; a1 = 32'hA111_1111; a2 = 32'hA222_2222; a3 = 32'hA333_3333;
        b0 = 32'hB000_0B00; b1 = 32'hB111_0B11; b2 = 32'hB222_0B22; b3 = 32'hB333_0B33;
        c0 = 32'hC0C0_C0C0; c1 = 32'hC1C1_C1C1;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_we", {63'd0, we}, 64'd0);
        check("rst_wway", {60'd0, wway}, 64'd0);
        check("rst_done", {63'd0, done_valid}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // 1: two rows at 3 to explicit way 0010
        do_req(5'd3, 6'd2, 4'b0010);
        check("t1_wway_lo", {60'd0, wway}, 64'h2);
        check("t1_req_ready_busy", {63'd0, req_ready}, 64'd0);
        send_beat(a0, 1'b0);
        check("t1_we_after_lo", {63'd0, we}, 64'd0);
        send_beat(a1, 1'b0);
        check("t1_we_row3", {63'd0, we}, 64'd1);
        check("t1_addr_row3", {59'd0, waddr}, 64'd3);
        check("t1_data_row3", wdata, {a1, a0});
        send_beat(a2, 1'b0);
        check("t1_we_gap", {63'd0, we}, 64'd0);
        check("t1_addr_hold", {59'd0, waddr}, 64'd3);
        send_beat(a3, 1'b1);
        check("t1_we_row4", {63'd0, we}, 64'd1);
        check("t1_addr_row4", {59'd0, waddr}, 64'd4);
        check("t1_data_row4", wdata, {a3, a2});
        check("t1_wway_flush", {60'd0, wway}, 64'h2);
        tick();
        check("t1_done", {63'd0, done_valid}, 64'd1);
        check("t1_err", {63'd0, done_err}, 64'd0);
        check("t1_done_way", {60'd0, done_way}, 64'h2);
        check("t1_wway_hold", {60'd0, wway}, 64'h2);
        check("t1_we_hold", {63'd0, we}, 64'd0);
        tick();
        check("t1_done_clear", {63'd0, done_valid}, 64'd0);
        check("t1_idle_ready", {63'd0, req_ready}, 64'd1);

        // 2: wrap from row 31 to row 0 with auto victim after reset
        do_reset();
        do_req(5'd31, 6'd2, 4'b0000);
        check("t2_wway_auto", {60'd0, wway}, 64'h1);
        send_beat(b0, 1'b0);
        send_beat(b1, 1'b0);
        check("t2_we_row31", {63'd0, we}, 64'd1);
        check("t2_addr_row31", {59'd0, waddr}, 64'd31);
        check("t2_data_row31", wdata, {b1, b0});
        send_beat(b2, 1'b0);
        send_beat(b3, 1'b1);
        check("t2_addr_row0", {59'd0, waddr}, 64'd0);
        check("t2_data_row0", wdata, {b3, b2});
        tick();
        check("t2_done_way", {60'd0, done_way}, 64'h1);
        check("t2_err", {63'd0, done_err}, 64'd0);
        tick();
        do_req(5'd1, 6'd1, 4'b0000);
        check("t2_wway_next_auto", {60'd0, wway}, 64'h2);
        send_beat(c0, 1'b0);
        send_beat(c1, 1'b1);
        check("t2_addr_row1", {59'd0, waddr}, 64'd1);
        tick();
        check("t2b_done_way", {60'd0, done_way}, 64'h2);
        tick();

        // 3: early last on the LO beat of the second row
        do_req(5'd5, 6'd2, 4'b0100);
        send_beat(b0, 1'b0);
        send_beat(b1, 1'b0);
        check("t3_addr_row5", {59'd0, waddr}, 64'd5);
        send_beat(b2, 1'b1);
        check("t3_no_partial_we", {63'd0, we}, 64'd0);
        check("t3_done", {63'd0, done_valid}, 64'd1);
        check("t3_err", {63'd0, done_err}, 64'd1);
        check("t3_done_way", {60'd0, done_way}, 64'h4);
        beat_data  = b3;
        beat_valid = 1'b1;
        check("t3_beat4_hold", {63'd0, beat_ready}, 64'd0);
        tick();
        check("t3_beat4_idle", {63'd0, beat_ready}, 64'd0);
        tick();
        check("t3_beat4_idle2", {63'd0, beat_ready}, 64'd0);
        check("t3_we_idle", {63'd0, we}, 64'd0);
        beat_valid = 1'b0;

        // 4: source stall between LO and HI
        do_req(5'd10, 6'd1, 4'b1000);
        send_beat(c0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_we", {63'd0, we}, 64'd0);
            tick();
        end
        send_beat(c1, 1'b1);
        check("t4_we", {63'd0, we}, 64'd1);
        check("t4_addr", {59'd0, waddr}, 64'd10);
        check("t4_data", wdata, {c1, c0});
        tick();
        check("t4_done", {63'd0, done_valid}, 64'd1);
        check("t4_err", {63'd0, done_err}, 64'd0);
        tick();

        // 5: reset while waiting for the HI beat
        do_req(5'd7, 6'd2, 4'b0010);
        send_beat(a0, 1'b0);
        rst_n      = 1'b0;
        beat_data  = a1;
        beat_valid = 1'b1;
        tick();
        check("t5_we", {63'd0, we}, 64'd0);
        check("t5_req_ready", {63'd0, req_ready}, 64'd0);
        check("t5_beat_ready", {63'd0, beat_ready}, 64'd0);
        check("t5_wway", {60'd0, wway}, 64'd0);
        check("t5_waddr", {59'd0, waddr}, 64'd0);
        check("t5_wdata", wdata, 64'd0);
        check("t5_done", {63'd0, done_valid}, 64'd0);
        rst_n      = 1'b1;
        beat_valid = 1'b0;
        tick();
        check("t5_req_ready_after", {63'd0, req_ready}, 64'd1);
        check("t5_we_after", {63'd0, we}, 64'd0);

        // 6: zero-length request with a beat waiting throughout
        beat_data  = b0;
        beat_valid = 1'b1;
        check("t6_idle_beat_ready", {63'd0, beat_ready}, 64'd0);
        do_req(5'd0, 6'd0, 4'b0001);
        check("t6_c1_beat_ready", {63'd0, beat_ready}, 64'd0);
        check("t6_c1_done", {63'd0, done_valid}, 64'd0);
        tick();
        check("t6_c2_done", {63'd0, done_valid}, 64'd1);
        check("t6_c2_err", {63'd0, done_err}, 64'd1);
        check("t6_c2_we", {63'd0, we}, 64'd0);
        check("t6_c2_beat_ready", {63'd0, beat_ready}, 64'd0);
        tick();
        check("t6_c3_beat_ready", {63'd0, beat_ready}, 64'd0);
        beat_valid = 1'b0;

        // Over-long request is rejected the same way
        do_req(5'd0, 6'd33, 4'b0001);
        tick();
        check("t6b_done", {63'd0, done_valid}, 64'd1);
        check("t6b_err", {63'd0, done_err}, 64'd1);
        tick();

        // Final HI beat without last: row written but flagged
        do_req(5'd2, 6'd1, 4'b0100);
        send_beat(a2, 1'b0);
        send_beat(a3, 1'b0);
        check("t7_we", {63'd0, we}, 64'd1);
        check("t7_data", wdata, {a3, a2});
        tick();
        check("t7_done", {63'd0, done_valid}, 64'd1);
        check("t7_err", {63'd0, done_err}, 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
